userio_osd_ctrl: RTL

USERIO_OSD_CTRL -- requirements
Module: userio_osd_ctrl

---
 rtl/userio_osd_ctrl.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/userio_osd_ctrl.sv
// rtl/userio_osd_ctrl.sv - SPI-driven OSD buffer writer and config registers
// Optional macro OSD_CLEAR_EN adds the 0x30 buffer-clear command and busy flag.
module userio_osd_ctrl #(
  parameter logic [3:0] VERSION = 4'h1
) (
  input  logic        clk,
  input  logic        _reset,
  input  logic        spi_rx,
  input  logic        spi_cmd,
  input  logic [7:0]  spi_data,
  output logic [7:0]  spi_in,
  output logic [10:0] buf_addr,
  output logic [7:0]  buf_data,
  output logic        buf_we,
  output logic        osd_enable,
  output logic [7:0]  cfg_chip,
  output logic [7:0]  cfg_mem,
  output logic        busy
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_WRBUF   = 3'd1;
  localparam logic [2:0] S_CFGCHIP = 3'd2;
  localparam logic [2:0] S_CFGMEM  = 3'd3;
  localparam logic [2:0] S_STATUS  = 3'd4;
  localparam logic [2:0] S_IGNORE  = 3'd5;
`ifdef OSD_CLEAR_EN
  localparam logic [2:0] S_CLEAR   = 3'd6;
`endif

  logic        rx_q;
  logic [2:0]  state_q, state_d;
  logic [2:0]  row_q, row_d;
  logic [7:0]  col_q, col_d;
  logic        we_q, we_d;
  logic [10:0] addr_q, addr_d;
  logic [7:0]  wdata_q, wdata_d;
  logic [7:0]  spi_in_q, spi_in_d;
  logic        osd_q, osd_d;
  logic [7:0]  chip_q, chip_d;
  logic [7:0]  mem_q, mem_d;
  logic        stat_q, stat_d;
  logic        busy_now;
  logic        evt;
`ifdef OSD_CLEAR_EN
  logic        busy_q, busy_d;
  logic [10:0] clr_q, clr_d;
  assign busy_now = busy_q;
`else
  assign busy_now = 1'b0;
`endif

  assign evt = (spi_rx != rx_q);

  always_comb begin
    state_d  = state_q;
    row_d    = row_q;
    col_d    = col_q;
    we_d     = 1'b0;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    spi_in_d = spi_in_q;
    osd_d    = osd_q;
    chip_d   = chip_q;
    mem_d    = mem_q;
    stat_d   = stat_q;
`ifdef OSD_CLEAR_EN
    busy_d   = busy_q;
    clr_d    = clr_q;
`endif
    if (evt && spi_cmd) begin
      // A command byte always restarts decoding, aborting whatever was running.
      spi_in_d = 8'hFF;
      stat_d   = 1'b0;
`ifdef OSD_CLEAR_EN
      busy_d   = 1'b0;
`endif
      if (spi_data[7:3] == 5'b00100) begin
        row_d   = spi_data[2:0];
        col_d   = 8'd0;
        state_d = S_WRBUF;
      end else if (spi_data[7:1] == 7'b0100000) begin
        osd_d   = spi_data[0];
        state_d = S_IGNORE;
      end else if (spi_data == 8'h50) begin
        state_d = S_CFGCHIP;
      end else if (spi_data == 8'h51) begin
        state_d = S_CFGMEM;
      end else if (spi_data == 8'h60) begin
        spi_in_d = {busy_now, osd_q, 2'b00, VERSION};
        state_d  = S_STATUS;
`ifdef OSD_CLEAR_EN
      end else if (spi_data == 8'h30) begin
        busy_d  = 1'b1;
        clr_d   = 11'd0;
        state_d = S_CLEAR;
`endif
      end else begin
        state_d = S_IGNORE;
      end
    end else if (evt) begin
      case (state_q)
        S_WRBUF: begin
          we_d    = 1'b1;
          addr_d  = {row_q, col_q};
          wdata_d = spi_data;
          col_d   = col_q + 8'd1;
        end
        S_CFGCHIP: begin
          chip_d  = spi_data;
          state_d = S_IGNORE;
        end
        S_CFGMEM: begin
          mem_d   = spi_data;
          state_d = S_IGNORE;
        end
        S_STATUS: begin
          spi_in_d = stat_q ? 8'hFF : chip_q;
          stat_d   = 1'b1;
        end
        default: ;
      endcase
    end
`ifdef OSD_CLEAR_EN
    // Data bytes during a clear fall through the case above and are dropped.
    if (state_q == S_CLEAR && !(evt && spi_cmd)) begin
      we_d    = 1'b1;
      addr_d  = clr_q;
      wdata_d = 8'h00;
      clr_d   = clr_q + 11'd1;
      if (clr_q == 11'h7FF) begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    end
`endif
  end

  // History follows spi_rx during reset so release never sees a phantom byte.
  always_ff @(posedge clk or negedge _reset) begin
    if (!_reset) begin
      rx_q     <= spi_rx;
      state_q  <= S_IDLE;
      row_q    <= 3'd0;
      col_q    <= 8'd0;
      we_q     <= 1'b0;
      addr_q   <= 11'd0;
      wdata_q  <= 8'd0;
      spi_in_q <= 8'hFF;
      osd_q    <= 1'b0;
      chip_q   <= 8'd0;
      mem_q    <= 8'd0;
      stat_q   <= 1'b0;
`ifdef OSD_CLEAR_EN
      busy_q   <= 1'b0;
      clr_q    <= 11'd0;
`endif
    end else begin
      rx_q     <= spi_rx;
      state_q  <= state_d;
      row_q    <= row_d;
      col_q    <= col_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      spi_in_q <= spi_in_d;
      osd_q    <= osd_d;
      chip_q   <= chip_d;
      mem_q    <= mem_d;
      stat_q   <= stat_d;
`ifdef OSD_CLEAR_EN
      busy_q   <= busy_d;
      clr_q    <= clr_d;
`endif
    end
  end

  assign spi_in     = spi_in_q;
  assign buf_addr   = addr_q;
  assign buf_data   = wdata_q;
  assign buf_we     = we_q;
  assign osd_enable = osd_q;
  assign cfg_chip   = chip_q;
  assign cfg_mem    = mem_q;
  assign busy       = busy_now;

endmodule
